// File: rtl/sa_result_drain.sv
// Result-matrix drain for the systolic array: settle, snapshot all Y outputs, stream them on valid/ready.
// Optional macro SA_DRAIN_TRANSPOSE_EN selects column-major stream order (default row-major).
module sa_result_drain #(
  parameter int ROWS          = 8,
  parameter int COLS          = 8,
  parameter int DW            = 16,
  parameter int SETTLE_CYCLES = 22
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      START,
  input  logic [ROWS*COLS*DW-1:0]   Y_FLAT,
  output logic [DW-1:0]             DOUT,
  output logic [$clog2(ROWS)-1:0]   DOUT_ROW,
  output logic [$clog2(COLS)-1:0]   DOUT_COL,
  output logic                      DOUT_VALID,
  input  logic                      DOUT_READY,
  output logic                      DOUT_LAST,
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int NUM  = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int IW   = $clog2(NUM);
  localparam int CNTW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    STREAM  = 3'd3,
    DONE_ST = 3'd4
  } state_t;

  // Stream position k -> matrix coordinates; the buffer itself is always stored row-major.
  function automatic logic [RW-1:0] idx_row(input logic [IW-1:0] k);
`ifdef SA_DRAIN_TRANSPOSE_EN
    return RW'(int'(k) % ROWS);
`else
    return RW'(int'(k) / COLS);
`endif
  endfunction

  function automatic logic [CW-1:0] idx_col(input logic [IW-1:0] k);
`ifdef SA_DRAIN_TRANSPOSE_EN
    return CW'(int'(k) / ROWS);
`else
    return CW'(int'(k) % COLS);
`endif
  endfunction

  function automatic logic [IW-1:0] idx_addr(input logic [IW-1:0] k);
    return IW'(int'(idx_row(k)) * COLS + int'(idx_col(k)));
  endfunction

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            capture_s;
  logic [IW-1:0]   nxt_idx_s;
  logic [DW-1:0]   buf_q [NUM];

  // Next-state and next-output logic; all outputs are registered one state ahead.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dout_d    = dout_q;
    row_d     = row_q;
    col_d     = col_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    capture_s = 1'b0;
    nxt_idx_s = idx_q + IW'(1);
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SETTLE;
          cnt_d   = CNTW'(SETTLE_CYCLES);
        end else begin
          busy_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == {CNTW{1'b0}}) begin
          state_d = CAPTURE;
        end else begin
          cnt_d   = cnt_q - CNTW'(1);
        end
      end
      CAPTURE: begin
        // Element (0,0) leads in either order, so the first beat comes straight from the tile.
        capture_s = 1'b1;
        state_d   = STREAM;
        idx_d     = {IW{1'b0}};
        valid_d   = 1'b1;
        last_d    = (LAST_IDX == {IW{1'b0}});
        dout_d    = Y_FLAT[DW-1:0];
        row_d     = {RW{1'b0}};
        col_d     = {CW{1'b0}};
      end
      STREAM: begin
        if (DOUT_READY) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE_ST;
            done_d  = 1'b1;
            dout_d  = {DW{1'b0}};
            row_d   = {RW{1'b0}};
            col_d   = {CW{1'b0}};
          end else begin
            idx_d   = nxt_idx_s;
            valid_d = 1'b1;
            last_d  = (nxt_idx_s == LAST_IDX);
            dout_d  = buf_q[idx_addr(nxt_idx_s)];
            row_d   = idx_row(nxt_idx_s);
            col_d   = idx_col(nxt_idx_s);
          end
        end else begin
          valid_d = 1'b1;
          last_d  = last_q;
        end
      end
      DONE_ST: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= {CNTW{1'b0}};
      idx_q   <= {IW{1'b0}};
      dout_q  <= {DW{1'b0}};
      row_q   <= {RW{1'b0}};
      col_q   <= {CW{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Snapshot buffer; contents are meaningless outside a drain, so no reset.
  always_ff @(posedge CLK) begin
    if (capture_s) begin
      for (int k = 0; k < NUM; k++) begin
        buf_q[k] <= Y_FLAT[k*DW +: DW];
      end
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_ROW   = row_q;
  assign DOUT_COL   = col_q;
  assign DOUT_VALID = valid_q;
  assign DOUT_LAST  = last_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule
